regfile_writeback: RTL and testbench

Write-back sequencer that owns the register file's single write port (address, data, write-enable) in the multi-cycle RISC datapath. Producers (ALU result, memory load) hand over destination/result pairs through a valid/ready handshake. The block buffers them in a small in-order queue and drains at most one per cycle into the register file when the control FSM permits. It also reports, per read address, whether a write is still pending, so the decode stage can stall (or forward, when configured) instead of reading a stale value.

---
 rtl/rf_pkg.sv | 12 +
 rtl/regfile_writeback_wb_fifo.sv | 79 +++++++
 rtl/regfile_writeback.sv | 118 +++++++++++
 tb/tb_regfile_writeback.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file constants and the write-back entry type
package rf_pkg;
    localparam int NUM_REGS = 8;
    localparam int AW       = 3;
    localparam int DW       = 16;
    localparam int REG_ZERO = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/regfile_writeback_wb_fifo.sv
// rtl/regfile_writeback_wb_fifo.sv - in-order write-back queue with age-ordered entry view
// REGFILE_WB_FWD_EN exposes per-entry data for the forwarding match.
module wb_fifo #(
    parameter int  DEPTH = 4,
    parameter int  AW    = rf_pkg::AW,
    parameter int  DW    = rf_pkg::DW,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [AW-1:0]            push_addr_i,
    input  logic [DW-1:0]            push_data_i,
    input  logic                     pop_i,
    output logic [AW-1:0]            head_addr_o,
    output logic [DW-1:0]            head_data_o,
    output logic [CW-1:0]            count_o,
    output logic [DEPTH-1:0]         ent_valid_o,
`ifdef REGFILE_WB_FWD_EN
    output logic [DEPTH-1:0][DW-1:0] ent_data_o,
`endif
    output logic [DEPTH-1:0][AW-1:0] ent_addr_o
);
    logic [AW-1:0] addr_mem_q [DEPTH];
    logic [DW-1:0] data_mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] slot [DEPTH];
    logic          do_push, do_pop;

    always_comb begin
        do_push  = push_i && (count_q != CW'(DEPTH));
        do_pop   = pop_i && (count_q != '0);
        wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_mem_q[wr_ptr_q] <= push_addr_i;
            data_mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Entry i is the i-th oldest; index 0 is the head.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            slot[i]        = rd_ptr_q + PW'(i);
            ent_valid_o[i] = CW'(i) < count_q;
            ent_addr_o[i]  = addr_mem_q[slot[i]];
`ifdef REGFILE_WB_FWD_EN
            ent_data_o[i]  = data_mem_q[slot[i]];
`endif
        end
    end

    assign head_addr_o = addr_mem_q[rd_ptr_q];
    assign head_data_o = data_mem_q[rd_ptr_q];
    assign count_o     = count_q;
endmodule

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - register-file write-port sequencer with pending-write detection
// REGFILE_WB_FWD_EN adds youngest-match forwarding outputs.
module regfile_writeback #(
    parameter int DEPTH = 4,
    parameter int AW    = 3,
    parameter int DW    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AW-1:0]          in_addr,
    input  logic [DW-1:0]          in_data,
    input  logic                   wb_en,
    output logic                   reg_wr,
    output logic [AW-1:0]          wr_addr,
    output logic [DW-1:0]          wr_data,
    input  logic [AW-1:0]          rs1,
    input  logic [AW-1:0]          rs2,
    output logic                   busy1,
    output logic                   busy2,
`ifdef REGFILE_WB_FWD_EN
    output logic                   fwd1_hit,
    output logic                   fwd2_hit,
    output logic [DW-1:0]          fwd1_data,
    output logic [DW-1:0]          fwd2_data,
`endif
    output logic [$clog2(DEPTH):0] count
);
    import rf_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]            count_w;
    logic [AW-1:0]            head_addr;
    logic [DW-1:0]            head_data;
    logic [DEPTH-1:0]         ent_valid;
    logic [DEPTH-1:0][AW-1:0] ent_addr;
`ifdef REGFILE_WB_FWD_EN
    logic [DEPTH-1:0][DW-1:0] ent_data;
`endif
    logic                     push, pop;
    logic                     reg_wr_q, reg_wr_d;
    logic [AW-1:0]            wr_addr_q, wr_addr_d;
    logic [DW-1:0]            wr_data_q, wr_data_d;
    logic                     hit1, hit2;

    assign in_ready = count_w < CW'(DEPTH);
    // r0 writes complete the handshake but never occupy the queue.
    assign push     = in_valid && in_ready && (in_addr != AW'(REG_ZERO));
    assign pop      = wb_en && (count_w != '0);

    wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_addr_i (in_addr),
        .push_data_i (in_data),
        .pop_i       (pop),
        .head_addr_o (head_addr),
        .head_data_o (head_data),
        .count_o     (count_w),
        .ent_valid_o (ent_valid),
`ifdef REGFILE_WB_FWD_EN
        .ent_data_o  (ent_data),
`endif
        .ent_addr_o  (ent_addr)
    );

    always_comb begin
        reg_wr_d  = pop;
        wr_addr_d = pop ? head_addr : wr_addr_q;
        wr_data_d = pop ? head_data : wr_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_wr_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            reg_wr_q  <= reg_wr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // The output stage counts as pending: the register file only sees it after this edge.
    always_comb begin
        hit1 = reg_wr_q && (wr_addr_q == rs1);
        hit2 = reg_wr_q && (wr_addr_q == rs2);
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_addr[i] == rs1)) hit1 = 1'b1;
            if (ent_valid[i] && (ent_addr[i] == rs2)) hit2 = 1'b1;
        end
        busy1 = hit1 && (rs1 != AW'(REG_ZERO));
        busy2 = hit2 && (rs2 != AW'(REG_ZERO));
    end

`ifdef REGFILE_WB_FWD_EN
    // Scan oldest to newest so the youngest match wins.
    always_comb begin
        fwd1_data = wr_data_q;
        fwd2_data = wr_data_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_addr[i] == rs1)) fwd1_data = ent_data[i];
            if (ent_valid[i] && (ent_addr[i] == rs2)) fwd2_data = ent_data[i];
        end
        fwd1_hit = busy1;
        fwd2_hit = busy2;
    end
`endif

    assign reg_wr  = reg_wr_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign count   = count_w;
endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - table-driven bench with write-order scoreboard for regfile_writeback
module tb_regfile_writeback;
    import rf_pkg::*;

    localparam int TD = 4;

    typedef struct {
        logic        valid;
        logic [2:0]  addr;
        logic [15:0] data;
        logic        wb;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic        exp_ready;
        logic [2:0]  exp_count;
        logic        exp_wr;
        logic        exp_b1;
        logic        exp_b2;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        in_valid, in_ready, wb_en, reg_wr, busy1, busy2;
    logic [2:0]  in_addr, wr_addr, rs1, rs2, count;
    logic [15:0] in_data, wr_data;
`ifdef REGFILE_WB_FWD_EN
    logic        fwd1_hit, fwd2_hit;
    logic [15:0] fwd1_data, fwd2_data;
`endif

    int        nvec = 0;
    int        nerr = 0;
    int        model_cnt = 0;
    wb_entry_t sb [$];
    vec_t      tbl [$];

    regfile_writeback #(.DEPTH(TD), .AW(3), .DW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .wb_en     (wb_en),
        .reg_wr    (reg_wr),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rs1       (rs1),
        .rs2       (rs2),
        .busy1     (busy1),
        .busy2     (busy2),
`ifdef REGFILE_WB_FWD_EN
        .fwd1_hit  (fwd1_hit),
        .fwd2_hit  (fwd2_hit),
        .fwd1_data (fwd1_data),
        .fwd2_data (fwd2_data),
`endif
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [2:0] a, input logic [15:0] d,
                                input logic wb, input logic [2:0] r1, input logic [2:0] r2,
                                input logic er, input logic [2:0] ec, input logic ew,
                                input logic eb1, input logic eb2);
        vec_t t;
        t.valid = v; t.addr = a; t.data = d; t.wb = wb; t.rs1 = r1; t.rs2 = r2;
        t.exp_ready = er; t.exp_count = ec; t.exp_wr = ew; t.exp_b1 = eb1; t.exp_b2 = eb2;
        return t;
    endfunction

    task automatic apply(input int idx, input vec_t v);
        logic acc, psh, pp;
        in_valid = v.valid; in_addr = v.addr; in_data = v.data;
        wb_en = v.wb; rs1 = v.rs1; rs2 = v.rs2;
        chk($sformatf("v%0d_ready_pre", idx), in_ready, model_cnt < TD);
        acc = v.valid && (model_cnt < TD);
        psh = acc && (v.addr != 3'd0);
        pp  = v.wb && (model_cnt > 0);
        if (psh) sb.push_back('{addr: v.addr, data: v.data});
        model_cnt = model_cnt + int'(psh) - int'(pp);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_count", idx), count, v.exp_count);
        chk($sformatf("v%0d_reg_wr", idx), reg_wr, v.exp_wr);
        chk($sformatf("v%0d_busy1", idx), busy1, v.exp_b1);
        chk($sformatf("v%0d_busy2", idx), busy2, v.exp_b2);
        chk($sformatf("v%0d_ready", idx), in_ready, v.exp_ready);
    endtask

    always @(negedge clk) begin
        if (!rst && reg_wr === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", {29'd0, wr_addr}, 32'hFFFF_FFFF);
            end else begin
                wb_entry_t e;
                e = sb.pop_front();
                chk("sb_wr_addr", wr_addr, e.addr);
                chk("sb_wr_data", wr_data, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0;
        wb_en = 1'b0; rs1 = 3'd3; rs2 = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", in_ready, 1);
        chk("rst_reg_wr", reg_wr, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_count", count, 0);
        chk("rst_busy1", busy1, 0);
        rst = 1'b0;

        // single write, full queue, r0 discard, simultaneous push/pop
        tbl.push_back(mk(1, 3, 16'h00AA, 1, 3, 0, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 3, 0, 1, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 3, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 16'h0101, 0, 4, 1, 1, 1, 0, 0, 1));
        tbl.push_back(mk(1, 2, 16'h0202, 0, 4, 1, 1, 2, 0, 0, 1));
        tbl.push_back(mk(1, 3, 16'h0303, 0, 4, 1, 1, 3, 0, 0, 1));
        tbl.push_back(mk(1, 4, 16'h0404, 0, 4, 1, 0, 4, 0, 1, 1));
        tbl.push_back(mk(1, 5, 16'h0505, 0, 4, 1, 0, 4, 0, 1, 1));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 4, 1, 1, 3, 1, 1, 1));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 4, 1, 1, 2, 1, 1, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 4, 1, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 4, 1, 1, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 4, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 16'hFFFF, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 6, 16'h0606, 0, 6, 7, 1, 1, 0, 1, 0));
        tbl.push_back(mk(1, 7, 16'h0707, 0, 6, 7, 1, 2, 0, 1, 1));
        tbl.push_back(mk(1, 5, 16'h0505, 1, 6, 7, 1, 2, 1, 1, 1));
        tbl.push_back(mk(1, 6, 16'h1616, 1, 6, 7, 1, 2, 1, 1, 1));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 6, 7, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 6, 7, 1, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 6, 7, 1, 0, 0, 0, 0));
        foreach (tbl[i]) apply(i, tbl[i]);

        // back-to-back writes wrapping the pointers
        for (int i = 0; i < 10; i++) begin
            apply(100 + i, mk(1, 3'((i % 7) + 1), 16'(16'h1000 + i), 1, 0, 0, 1, 1, i != 0, 0, 0));
        end
        apply(110, mk(0, 0, 16'h0000, 1, 0, 0, 1, 0, 1, 0, 0));
        apply(111, mk(0, 0, 16'h0000, 1, 0, 0, 1, 0, 0, 0, 0));

        // duplicate destination, then reset with a write in flight
        apply(200, mk(1, 5, 16'h0011, 0, 5, 2, 1, 1, 0, 1, 0));
        apply(201, mk(1, 5, 16'h0022, 0, 5, 2, 1, 2, 0, 1, 0));
`ifdef REGFILE_WB_FWD_EN
        chk("fwd1_hit", fwd1_hit, 1);
        chk("fwd1_data_youngest", fwd1_data, 16'h0022);
        chk("fwd2_hit", fwd2_hit, 0);
`endif
        apply(202, mk(1, 2, 16'h0033, 0, 5, 2, 1, 3, 0, 1, 1));
        apply(203, mk(1, 3, 16'h0044, 1, 5, 2, 1, 3, 1, 1, 1));
        chk("pre_rst_wr_addr", wr_addr, 5);
        chk("pre_rst_wr_data", wr_data, 16'h0011);
`ifdef REGFILE_WB_FWD_EN
        chk("fwd1_entry_over_stage", fwd1_data, 16'h0022);
        chk("fwd2_data", fwd2_data, 16'h0033);
`endif
        rst = 1'b1;
        sb.delete();
        model_cnt = 0;
        #1;
        chk("midrst_reg_wr", reg_wr, 0);
        chk("midrst_count", count, 0);
        chk("midrst_ready", in_ready, 1);
        chk("midrst_busy1", busy1, 0);
        chk("midrst_busy2", busy2, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) apply(300 + i, mk(0, 0, 16'h0000, 1, 5, 2, 1, 0, 0, 0, 0));

        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
